// File: rtl/sad_search_ctrl.sv
// Search sequencer for the pipelined SAD datapath: issues every window position in
// raster order, bounds in-flight requests and tracks the minimum returned SAD.
module sad_search_ctrl #(
    parameter int unsigned FRAME_W = 64,
    parameter int unsigned FRAME_H = 64,
    parameter int unsigned WIN_W   = 4,
    parameter int unsigned WIN_H   = 4,
    parameter int unsigned SAD_W   = 32,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CW      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [CW-1:0]    issue_row,
    output logic [CW-1:0]    issue_col,
    input  logic             res_valid,
    input  logic [SAD_W-1:0] res_sad,
    output logic [SAD_W-1:0] best_sad,
    output logic [CW-1:0]    best_row,
    output logic [CW-1:0]    best_col,
    output logic             err
);

    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] LAST_COL = CW'(FRAME_W - WIN_W);
    localparam logic [CW-1:0] LAST_ROW = CW'(FRAME_H - WIN_H);
    localparam logic [OW-1:0] MAX_CNT  = OW'(MAX_OUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_issue_valid;
    logic [CW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic [CW-1:0]   r_trk_row;
    logic [CW-1:0]   r_trk_col;
    logic [SAD_W-1:0] r_best_sad;
    logic [CW-1:0]   r_best_row;
    logic [CW-1:0]   r_best_col;
    logic            r_err;
    logic [OW-1:0]   r_out;

    logic            w_hs;
    logic            w_res_ok;
    logic            w_res_bad;
    logic            w_better;
    logic            w_last_pos;
    logic [OW-1:0]   w_out_nxt;

    assign w_hs       = r_issue_valid & issue_ready;
    assign w_res_ok   = res_valid & (r_out != '0);
    assign w_res_bad  = res_valid & (r_out == '0);
    assign w_better   = w_res_ok & (res_sad < r_best_sad);
    assign w_last_pos = (r_row == LAST_ROW) & (r_col == LAST_COL);

    // Outstanding count after this edge; a coincident issue and return cancel out.
    always_comb begin
        w_out_nxt = r_out;
        case ({w_hs, w_res_ok})
            2'b10:   w_out_nxt = r_out + OW'(1);
            2'b01:   w_out_nxt = r_out - OW'(1);
            default: w_out_nxt = r_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_issue_valid <= 1'b0;
            r_row         <= '0;
            r_col         <= '0;
            r_trk_row     <= '0;
            r_trk_col     <= '0;
            r_best_sad    <= '1;
            r_best_row    <= '0;
            r_best_col    <= '0;
            r_err         <= 1'b0;
            r_out         <= '0;
        end else begin
            r_done <= 1'b0;
            r_out  <= w_out_nxt;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state       <= S_ISSUE;
                        r_busy        <= 1'b1;
                        r_issue_valid <= 1'b1;
                        r_row         <= '0;
                        r_col         <= '0;
                        r_trk_row     <= '0;
                        r_trk_col     <= '0;
                        r_best_sad    <= '1;
                        r_best_row    <= '0;
                        r_best_col    <= '0;
                        r_err         <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (w_hs && w_last_pos) begin
                        r_state       <= S_DRAIN;
                        r_issue_valid <= 1'b0;
                    end else begin
                        r_issue_valid <= (w_out_nxt < MAX_CNT);
                        if (w_hs) begin
                            if (r_col == LAST_COL) begin
                                r_col <= '0;
                                r_row <= r_row + CW'(1);
                            end else begin
                                r_col <= r_col + CW'(1);
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_out_nxt == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Results return in issue order, so the tracker names the oldest request.
            if (w_res_ok) begin
                if (r_trk_col == LAST_COL) begin
                    r_trk_col <= '0;
                    r_trk_row <= r_trk_row + CW'(1);
                end else begin
                    r_trk_col <= r_trk_col + CW'(1);
                end
                if (w_better) begin
                    r_best_sad <= res_sad;
                    r_best_row <= r_trk_row;
                    r_best_col <= r_trk_col;
                end
            end

            if (w_res_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign issue_valid = r_issue_valid;
    assign issue_row   = r_row;
    assign issue_col   = r_col;
    assign best_sad    = r_best_sad;
    assign best_row    = r_best_row;
    assign best_col    = r_best_col;
    assign err         = r_err;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl on an 8x8 frame with 4x4 windows.
module tb_sad_search_ctrl;

    localparam int unsigned FW   = 8;
    localparam int unsigned FH   = 8;
    localparam int unsigned WW   = 4;
    localparam int unsigned WH   = 4;
    localparam int unsigned SW   = 32;
    localparam int unsigned MO   = 4;
    localparam int unsigned C    = 16;
    localparam int unsigned NX   = FW - WW + 1;
    localparam int          LAT  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          issue_valid;
    logic          issue_ready;
    logic [C-1:0]  issue_row;
    logic [C-1:0]  issue_col;
    logic          res_valid;
    logic [SW-1:0] res_sad;
    logic [SW-1:0] best_sad;
    logic [C-1:0]  best_row;
    logic [C-1:0]  best_col;
    logic          err;

    sad_search_ctrl #(
        .FRAME_W(FW), .FRAME_H(FH), .WIN_W(WW), .WIN_H(WH),
        .SAD_W(SW), .MAX_OUT(MO), .CW(C)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_row(issue_row), .issue_col(issue_col),
        .res_valid(res_valid), .res_sad(res_sad),
        .best_sad(best_sad), .best_row(best_row), .best_col(best_col),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    int cyc      = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;
    int exp_r    = 0;
    int exp_c    = 0;
    bit ret_en   = 1'b1;
    bit inj_res  = 1'b0;
    int sad_mode = 0;
    int rdy_mode = 0;
    int due_q[$];
    int idx_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [SW-1:0] sad_of(input int i);
        case (sad_mode)
            0:       sad_of = SW'(100 - 4 * i);
            1:       sad_of = SW'(50);
            default: sad_of = SW'((i * 11 + 7) % 25 + 5);
        endcase
    endfunction

    // One clock: drive inputs at the falling edge, model the datapath, step to the next falling edge.
    task automatic run_cycle();
        bit           stall;
        logic [C-1:0] sr;
        logic [C-1:0] sc;
        if (rdy_mode == 0) issue_ready = 1'b1;
        else               issue_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        res_valid = 1'b0;
        res_sad   = '0;
        if (inj_res) begin
            res_valid = 1'b1;
            res_sad   = SW'(1);
            inj_res   = 1'b0;
        end else if (ret_en && due_q.size() > 0 && due_q[0] == cyc) begin
            res_valid = 1'b1;
            res_sad   = sad_of(idx_q[0]);
            void'(due_q.pop_front());
            void'(idx_q.pop_front());
        end
        if (done) done_cnt++;
        if (issue_valid && issue_ready) begin
            check("hs_row", 32'(issue_row), 32'(exp_r));
            check("hs_col", 32'(issue_col), 32'(exp_c));
            due_q.push_back(cyc + LAT);
            idx_q.push_back(hs_cnt);
            hs_cnt++;
            if (exp_c == NX - 1) begin
                exp_c = 0;
                exp_r++;
            end else begin
                exp_c++;
            end
        end
        stall = issue_valid && !issue_ready;
        sr    = issue_row;
        sc    = issue_col;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (stall) begin
            check("stall_row", 32'(issue_row), 32'(sr));
            check("stall_col", 32'(issue_col), 32'(sc));
        end
    endtask

    task automatic start_search();
        exp_r  = 0;
        exp_c  = 0;
        hs_cnt = 0;
        start  = 1'b1;
        run_cycle();
        start  = 1'b0;
    endtask

    task automatic run_to_done(input string tag);
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        while (!done && n < 400) begin
            run_cycle();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_hs_total"}, 32'(hs_cnt), 32'd25);
        if (done) begin
            run_cycle();
            run_cycle();
            check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
            check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_ivld"},  32'(issue_valid), 32'd0);
        check({tag, "_irow"},  32'(issue_row), 32'd0);
        check({tag, "_icol"},  32'(issue_col), 32'd0);
        check({tag, "_bsad"},  best_sad, 32'hFFFF_FFFF);
        check({tag, "_brow"},  32'(best_row), 32'd0);
        check({tag, "_bcol"},  32'(best_col), 32'd0);
        check({tag, "_err"},   32'(err), 32'd0);
    endtask

    initial begin
        int n;
        int h0;
        int d0;
        rst         = 1'b0;
        start       = 1'b0;
        issue_ready = 1'b0;
        res_valid   = 1'b0;
        res_sad     = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("por");
        rst = 1'b1;
        run_cycle();

        // Full search with descending SADs: minimum is the last position
        ret_en = 1'b1; sad_mode = 0; rdy_mode = 0;
        start_search();
        check("t1_busy", 32'(busy), 32'd1);
        run_to_done("t1");
        check("t1_best_sad", best_sad, 32'd4);
        check("t1_best_row", 32'(best_row), 32'd4);
        check("t1_best_col", 32'(best_col), 32'd4);

        // Unexpected result in IDLE sets err and leaves best untouched
        inj_res = 1'b1;
        run_cycle();
        check("t5_err", 32'(err), 32'd1);
        check("t5_best_sad", best_sad, 32'd4);
        check("t5_best_row", 32'(best_row), 32'd4);
        run_cycle();
        check("t5_err_sticky", 32'(err), 32'd1);

        // Next start clears err; constant SAD keeps the first position
        sad_mode = 1;
        start_search();
        check("t3_err_cleared", 32'(err), 32'd0);
        check("t3_best_init", best_sad, 32'hFFFF_FFFF);
        run_to_done("t3");
        check("t3_best_sad", best_sad, 32'd50);
        check("t3_best_row", 32'(best_row), 32'd0);
        check("t3_best_col", 32'(best_col), 32'd0);

        // Datapath never answers: issue stops at the in-flight limit
        ret_en = 1'b0; sad_mode = 0;
        d0 = done_cnt;
        start_search();
        for (int i = 0; i < 30; i++) run_cycle();
        check("t2_hs", 32'(hs_cnt), 32'(MO));
        check("t2_ivld", 32'(issue_valid), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_no_done", 32'(done_cnt - d0), 32'd0);
        rst = 1'b0;
        run_cycle();
        rst = 1'b1;
        due_q.delete();
        idx_q.delete();
        run_cycle();

        // Ready toggling 1,0,0,1 with results landing on handshake cycles
        ret_en = 1'b1; sad_mode = 2; rdy_mode = 1;
        start_search();
        run_to_done("t4");
        check("t4_best_sad", best_sad, 32'd5);
        check("t4_best_row", 32'(best_row), 32'd2);
        check("t4_best_col", 32'(best_col), 32'd3);

        // Reset mid-search after 7 handshakes; stale results flag err afterwards
        sad_mode = 0; rdy_mode = 0;
        start_search();
        n = 0;
        while (hs_cnt < 7 && n < 50) begin
            run_cycle();
            n++;
        end
        check("t6_hs7", 32'(hs_cnt), 32'd7);
        rst = 1'b0;
        #1;
        check_reset_vals("t6_async");
        run_cycle();
        rst = 1'b1;
        run_cycle();
        check("t6_stale_err", 32'(err), 32'd1);
        for (int i = 0; i < 4; i++) run_cycle();
        due_q.delete();
        idx_q.delete();
        h0 = done_cnt;
        start_search();
        check("t6_restart_ivld", 32'(issue_valid), 32'd1);
        check("t6_restart_row", 32'(issue_row), 32'd0);
        check("t6_restart_col", 32'(issue_col), 32'd0);
        check("t6_restart_err", 32'(err), 32'd0);
        run_to_done("t6");
        check("t6_best_sad", best_sad, 32'd4);
        check("t6_best_row", 32'(best_row), 32'd4);
        check("t6_best_col", 32'(best_col), 32'd4);
        check("t6_err_final", 32'(err), 32'd0);
        check("t6_one_done", 32'(done_cnt - h0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
